// File: rtl/uart_pkg.sv
// Shared UART register map, STAT/CTRL bit positions and host-interface FSM states.
package uart_pkg;

  localparam logic [31:0] UART_RX_OFF   = 32'h0;
  localparam logic [31:0] UART_TX_OFF   = 32'h4;
  localparam logic [31:0] UART_STAT_OFF = 32'h8;
  localparam logic [31:0] UART_CTRL_OFF = 32'hC;

  localparam int unsigned STAT_RX_VALID_BIT = 0;
  localparam int unsigned STAT_BREAK_BIT    = 3;
  localparam int unsigned STAT_TX_FULL_BIT  = 4;

  // Writing this to CTRL clears a pending BREAK and leaves all interrupt enables off.
  localparam int unsigned CTRL_CLR_BREAK_BIT = 4;
  localparam logic [31:0] CTRL_CLR_BREAK     = 32'h0000_0010;

  typedef enum logic [2:0] {
    POLL_REQ,
    POLL_RSP,
    RX_REQ,
    RX_RSP,
    TX_REQ,
    BRK_REQ,
    GAP
  } uart_state_e;

endpackage

// File: rtl/scarv_ccx_memif.sv
// Simple request/grant memory interface; read data returns one cycle after grant.
interface scarv_ccx_memif;

  logic        req;
  logic        wen;
  logic [3:0]  strb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic [31:0] rdata;
  logic        error;

  modport REQ (output req, wen, strb, addr, wdata, input gnt, rdata, error);
  modport RSP (input req, wen, strb, addr, wdata, output gnt, rdata, error);

endinterface

// File: rtl/uart_host_if.sv
// Polls a memory-mapped UART over memif and bridges its RX/TX data registers to
// valid/ready byte ports. Define UART_HOST_BREAK_EN to detect and clear UART BREAK.
module uart_host_if #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_1000,
  parameter int unsigned POLL_GAP  = 16
) (
  input  logic        g_clk,
  input  logic        g_reset,
  scarv_ccx_memif.REQ memif,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [7:0]  tx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_break,
  output logic        err
);

  import uart_pkg::*;

  localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);

  uart_state_e state_q, state_d;
  logic        started_q;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic        tx_full_q, tx_full_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        rx_valid_q, rx_valid_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        err_q, err_d;

  logic        req_c;
  logic        wen_c;
  logic [3:0]  strb_c;
  logic [31:0] addr_c;
  logic [31:0] wdata_c;
  logic        tx_hs;
  logic        unused_rdata;

`ifdef UART_HOST_BREAK_EN
  logic rx_break_q, rx_break_d;
`endif

  always_comb begin
    state_d    = state_q;
    gap_cnt_d  = gap_cnt_q;
    tx_full_d  = tx_full_q;
    tx_byte_d  = tx_byte_q;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    err_d      = err_q;
    req_c      = 1'b0;
    wen_c      = 1'b0;
    strb_c     = '0;
    addr_c     = '0;
    wdata_c    = '0;
`ifdef UART_HOST_BREAK_EN
    rx_break_d = 1'b0;
`endif

    tx_hs = tx_valid && !tx_full_q;
    if (tx_hs) begin
      tx_full_d = 1'b1;
      tx_byte_d = tx_data;
    end
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      POLL_REQ: begin
        // started_q keeps req low in the first cycle out of reset.
        req_c  = started_q;
        addr_c = BASE_ADDR + UART_STAT_OFF;
        if (started_q && memif.gnt) begin
          state_d = POLL_RSP;
        end
      end
      POLL_RSP: begin
        if (memif.error) begin
          err_d   = 1'b1;
          state_d = GAP;
`ifdef UART_HOST_BREAK_EN
        end else if (memif.rdata[STAT_BREAK_BIT]) begin
          state_d = BRK_REQ;
`endif
        end else if (memif.rdata[STAT_RX_VALID_BIT] && !rx_valid_q) begin
          state_d = RX_REQ;
        end else if (tx_full_q && !memif.rdata[STAT_TX_FULL_BIT]) begin
          state_d = TX_REQ;
        end else begin
          state_d = GAP;
        end
      end
      RX_REQ: begin
        req_c  = 1'b1;
        addr_c = BASE_ADDR + UART_RX_OFF;
        if (memif.gnt) begin
          state_d = RX_RSP;
        end
      end
      RX_RSP: begin
        if (memif.error) begin
          err_d   = 1'b1;
          state_d = GAP;
        end else begin
          rx_data_d  = memif.rdata[7:0];
          rx_valid_d = 1'b1;
          state_d    = POLL_REQ;
        end
      end
      TX_REQ: begin
        req_c   = 1'b1;
        wen_c   = 1'b1;
        strb_c  = 4'b0001;
        addr_c  = BASE_ADDR + UART_TX_OFF;
        wdata_c = {24'b0, tx_byte_q};
        if (memif.gnt) begin
          tx_full_d = 1'b0;
          state_d   = POLL_REQ;
        end
      end
      BRK_REQ: begin
`ifdef UART_HOST_BREAK_EN
        req_c   = 1'b1;
        wen_c   = 1'b1;
        strb_c  = 4'b0001;
        addr_c  = BASE_ADDR + UART_CTRL_OFF;
        wdata_c = CTRL_CLR_BREAK;
        if (memif.gnt) begin
          rx_break_d = 1'b1;
          state_d    = POLL_REQ;
        end
`else
        state_d = POLL_REQ;
`endif
      end
      GAP: begin
        // A freshly accepted TX byte cuts the idle gap short.
        if (tx_hs || gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = POLL_REQ;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = POLL_REQ;
      end
    endcase
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q    <= POLL_REQ;
      started_q  <= 1'b0;
      gap_cnt_q  <= '0;
      tx_full_q  <= 1'b0;
      tx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      started_q  <= 1'b1;
      gap_cnt_q  <= gap_cnt_d;
      tx_full_q  <= tx_full_d;
      tx_byte_q  <= tx_byte_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      err_q      <= err_d;
    end
  end

`ifdef UART_HOST_BREAK_EN
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      rx_break_q <= 1'b0;
    end else begin
      rx_break_q <= rx_break_d;
    end
  end
  assign rx_break = rx_break_q;
`else
  assign rx_break = 1'b0;
`endif

  assign memif.req   = req_c;
  assign memif.wen   = wen_c;
  assign memif.strb  = strb_c;
  assign memif.addr  = addr_c;
  assign memif.wdata = wdata_c;

  assign tx_ready = !tx_full_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign err      = err_q;

  assign unused_rdata = ^memif.rdata[31:8];

endmodule

// File: doc/uart_host_if.md
UART_HOST_IF -- requirements
Module: uart_host_if

Interface
REQ-001 Parameter BASE_ADDR, default 32'h4000_1000, SHALL be the byte address of the UART register block (RX +0x0, TX +0x4, STAT +0x8, CTRL +0xC).
REQ-002 Parameter POLL_GAP, default 16, SHALL be the idle cycles between an empty STAT poll and the next poll (range 1..255).
REQ-003 g_clk  in  1  single clock; all logic rises on it.
REQ-004 g_reset  in  1  asynchronous, active-high reset.
REQ-005 memif  scarv_ccx_memif.REQ  -  memif master port driving the UART (req, wen, strb, addr, wdata out; gnt, rdata, error in).
REQ-006 tx_valid  in  1  TX byte offered.
REQ-007 tx_ready  out  1  TX byte accepted this cycle when tx_valid is also high.
REQ-008 tx_data  in  8  TX byte.
REQ-009 rx_valid  out  1  RX byte available.
REQ-010 rx_ready  in  1  consumer takes the RX byte.
REQ-011 rx_data  out  8  RX byte.
REQ-012 rx_break  out  1  one-cycle pulse when a UART BREAK is cleared.
REQ-013 err  out  1  sticky bus-error flag.

Function
REQ-014 FSM states SHALL be POLL_REQ, POLL_RSP, RX_REQ, RX_RSP, TX_REQ, BRK_REQ, GAP.
REQ-015 Memif rules: addr, wen, strb, wdata stable while req high; request completes in the cycle req&&gnt; read rdata/error sampled exactly one cycle after gnt; writes have no response phase.
REQ-016 POLL_REQ: read BASE_ADDR+0x8; on gnt go to POLL_RSP.
REQ-017 POLL_RSP decode, strict priority: STAT[3] break set -> BRK_REQ; STAT[0] rx_valid set and RX holding register empty -> RX_REQ; TX holding register full and STAT[4] tx_full clear -> TX_REQ; otherwise -> GAP.
REQ-018 RX_REQ: read BASE_ADDR+0x0; RX_RSP loads rdata[7:0] into the RX holding register, sets rx_valid, then goes to POLL_REQ.
REQ-019 TX_REQ: write BASE_ADDR+0x4, strb 4'b0001, wdata {24'b0, held byte}; on gnt clear the TX holding register and go to POLL_REQ.
REQ-020 BRK_REQ: write BASE_ADDR+0xC, wdata 32'h10 (clear break, interrupt enables 0), strb 4'b0001; on gnt pulse rx_break one cycle, go to POLL_REQ.
REQ-021 GAP: count POLL_GAP cycles, then POLL_REQ; a tx_valid&&tx_ready handshake during GAP SHALL end GAP early next cycle.
REQ-022 tx_ready = TX holding register empty; simultaneous handshake and TX_REQ completion in one cycle is impossible by construction (ready low while full).
REQ-023 rx_valid held with stable rx_data until rx_valid&&rx_ready; a byte taken the same cycle RX_RSP loads is impossible (REQ-017 requires empty register).
REQ-024 error high in any response cycle SHALL set err, discard rdata, and go to GAP; err clears only on reset.
REQ-025 memif.req SHALL be high only in *_REQ states; throughput bound: one RX byte per 4 cycles at gnt=1.

Reset
REQ-026 On g_reset: state POLL_REQ, memif.req 0, tx_ready 1, rx_valid 0, rx_data 0, rx_break 0, err 0, GAP counter 0, both holding registers empty; reset mid-transaction abandons it without completing the memif beat.

Configuration
REQ-027 With UART_HOST_BREAK_EN defined: REQ-017 break branch, BRK_REQ and rx_break active.
REQ-028 Without UART_HOST_BREAK_EN: STAT[3] ignored, BRK_REQ never entered, rx_break tied 0.

Structure
REQ-029 Shared uart_pkg SHALL hold register offsets, STAT/CTRL bit positions, and the FSM state enum; uart_top uses the same offsets.
REQ-030 Single module, no sub-module; GAP counter and holding registers inline.

Verification
REQ-031 Reset, STAT=0x00 each poll, gnt=1 -> polls every POLL_GAP+2 cycles, rx_valid 0, tx_ready 1.
REQ-032 STAT=0x01, RX rdata=0x5A -> rx_valid 1, rx_data 0x5A, held until rx_ready; no second RX read while held.
REQ-033 tx_data 0xA5 handshake, STAT=0x10 twice then 0x00 -> no TX write until third poll, then write addr BASE+0x4 wdata 0xA5 strb 0x1.
REQ-034 STAT=0x09 (break+rx_valid) with UART_HOST_BREAK_EN -> CTRL write 0x10 first, rx_break pulse, then RX read; without the macro -> RX read only.
REQ-035 error=1 on POLL_RSP -> err 1 sticky, FSM enters GAP; g_reset asserted mid RX_REQ with gnt=0 -> req 0 immediately, all outputs reset values.
